// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the word-merge helper for the
// D-cache data array.
package dcache_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam int DEF_WIDTH        = 512;
    localparam int DEF_LOG_NUM_ROWS = 9;
    localparam int DEF_WORD_SIZE    = 64;

    localparam int NUM_ROWS  = 2 ** DEF_LOG_NUM_ROWS;
    localparam int NUM_WORDS = DEF_WIDTH / DEF_WORD_SIZE;

    // Widest row the merge helper handles; narrower rows are zero-extended.
    localparam int MAX_WIDTH = 1024;
    localparam int MAX_IDX_W = $clog2(MAX_WIDTH);

    // Take word i from newRow where mask[i] is set, else from oldRow.
    function automatic logic [MAX_WIDTH-1:0] merge(
        input logic [MAX_WIDTH-1:0] oldRow,
        input logic [MAX_WIDTH-1:0] newRow,
        input logic [MAX_WIDTH-1:0] mask,
        input int                   wordSize
    );
        logic [MAX_WIDTH-1:0] res;
        res = oldRow;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (mask[MAX_IDX_W'(b / wordSize)]) begin
                res[MAX_IDX_W'(b)] = newRow[MAX_IDX_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_read_pipe.sv
// Read-data pipeline for the D-cache data array: one or two register
// stages carrying data and a valid strobe, flushed by reset.
module dcache_read_pipe
    import dcache_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             validOut,
    output logic [WIDTH-1:0] dataOut
);

    logic             valid1;
    logic [WIDTH-1:0] data1;

    // First stage: capture array output for accepted reads, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1 <= 1'b0;
            data1  <= '0;
        end else begin
            valid1 <= validIn;
            if (validIn) begin
                data1 <= dataIn;
            end
        end
    end

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
        $error("dcache_read_pipe: READ_LATENCY must be 1 or 2");
    end

    if (READ_LATENCY == 2) begin : gTwo
        logic             valid2;
        logic [WIDTH-1:0] data2;

        // Second stage: re-register the first stage, holding data when idle.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid2 <= 1'b0;
                data2  <= '0;
            end else begin
                valid2 <= valid1;
                if (valid1) begin
                    data2 <= data1;
                end
            end
        end

        assign validOut = valid2;
        assign dataOut  = data2;
    end else begin : gOne
        assign validOut = valid1;
        assign dataOut  = data1;
    end

endmodule

// File: rtl/dcache_data_array.sv
// Word-masked D-cache data array with hardware clear FSM and 1/2-cycle
// read pipeline. Define DCACHE_RAW_BYPASS_EN for write-first same-row reads.
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int                   WIDTH        = DEF_WIDTH,
    parameter int                   LOG_NUM_ROWS = DEF_LOG_NUM_ROWS,
    parameter int                   WORD_SIZE    = DEF_WORD_SIZE,
    parameter int                   READ_LATENCY = 1,
    parameter logic [WORD_SIZE-1:0] INIT_VALUE   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         readEn,
    input  logic [LOG_NUM_ROWS-1:0]      readAddr,
    output logic [WIDTH-1:0]             readData,
    output logic                         readValid,
    input  logic [LOG_NUM_ROWS-1:0]      writeAddr,
    input  logic [WIDTH-1:0]             writeData,
    input  logic [WIDTH/WORD_SIZE-1:0]   writeEnable,
    output logic                         initBusy
);

    localparam int ROWS  = 2 ** LOG_NUM_ROWS;
    localparam int WORDS = WIDTH / WORD_SIZE;

    if (WIDTH % WORD_SIZE != 0 || WIDTH > MAX_WIDTH) begin : gBadWidth
        $error("dcache_data_array: bad WIDTH/WORD_SIZE combination");
    end

    state_t                  state;
    logic [LOG_NUM_ROWS-1:0] clrRow;
    logic [WIDTH-1:0]        mem [ROWS];

    logic             ready;
    logic             readFire;
    logic [WIDTH-1:0] arrayRow;
    logic [WIDTH-1:0] writeRow;
    logic [WIDTH-1:0] pipeIn;

    assign ready    = (state == READY);
    assign readFire = ready && readEn;
    assign initBusy = !ready;
    assign arrayRow = mem[readAddr];

    assign writeRow = WIDTH'(merge(MAX_WIDTH'(mem[writeAddr]),
                                   MAX_WIDTH'(writeData),
                                   MAX_WIDTH'(writeEnable),
                                   WORD_SIZE));

    // Clear sequencer: walk every row once after reset, then stay READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            clrRow <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clrRow <= clrRow + 1'b1;
                    if (&clrRow) begin
                        state <= READY;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Storage update: clear pattern during CLEAR, masked writes when READY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clrRow] <= {WORDS{INIT_VALUE}};
            end else if (|writeEnable) begin
                mem[writeAddr] <= writeRow;
            end
        end
    end

`ifdef DCACHE_RAW_BYPASS_EN
    logic bypassHit;

    assign bypassHit = ready && (|writeEnable) && (readAddr == writeAddr);
    assign pipeIn    = bypassHit
                     ? WIDTH'(merge(MAX_WIDTH'(arrayRow),
                                    MAX_WIDTH'(writeData),
                                    MAX_WIDTH'(writeEnable),
                                    WORD_SIZE))
                     : arrayRow;
`else
    assign pipeIn = arrayRow;
`endif

    dcache_read_pipe #(
        .WIDTH        (WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) uReadPipe (
        .clk      (clk),
        .reset    (reset),
        .validIn  (readFire),
        .dataIn   (pipeIn),
        .validOut (readValid),
        .dataOut  (readData)
    );

endmodule
